window_serializer_5x5: RTL and testbench



---
 rtl/window_pkg.sv | 18 +
 rtl/window_serializer_5x5_controller.sv | 103 ++++++++++
 rtl/window_serializer_5x5.sv | 111 +++++++++++
 tb/tb_window_serializer_5x5.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared types and constants for the 5x5 window serializer.
// Defines pixel geometry, FSM state encoding and the row-index type.
package window_pkg;

    localparam int WIN_DIM = 5;
    localparam int PIX_W   = 8;
    localparam int WIN_PIX = WIN_DIM * WIN_DIM;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef logic [2:0] row_t;

    localparam row_t LAST_ROW = 3'd4;

endpackage

// File: rtl/window_serializer_5x5_controller.sv
// Sequencing for the window serializer: IDLE/EMIT FSM, row counter and the
// per-frame window counter that produces done_o.
module window_serializer_5x5_controller
    import window_pkg::*;
#(
    parameter int ROWS = 7,
    parameter int COLS = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    output logic ready_o,
    output logic accept_o,
    output logic valid_o,
    output logic last_o,
    output logic done_o,
    output row_t row_o
);

    localparam int FRAME_LEN = ROWS * COLS;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    row_t             r_row;
    row_t             w_row_nxt;
    logic [CNT_W-1:0] r_frame;
    logic [CNT_W-1:0] w_frame_nxt;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_done;

    // Handshake and frame-boundary decode from registered state only.
    always_comb begin
        w_last   = (r_state == EMIT) && (r_row == LAST_ROW);
        w_ready  = (r_state == IDLE) || w_last;
        w_accept = valid_i && w_ready;
        w_done   = w_last && (r_frame == FRAME_END);
    end

    // Next-state logic for the FSM, row counter and frame counter.
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_frame_nxt = r_frame;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = EMIT;
                    w_row_nxt   = 3'd0;
                end else begin
                    w_state_nxt = IDLE;
                    w_row_nxt   = 3'd0;
                end
            end
            EMIT: begin
                if (r_row != LAST_ROW) begin
                    w_row_nxt = r_row + 3'd1;
                end else if (w_accept) begin
                    w_row_nxt = 3'd0;
                end else begin
                    w_state_nxt = IDLE;
                    w_row_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_row_nxt   = 3'd0;
            end
        endcase
        // The increment that completes the frame wraps straight back to zero.
        if (w_done) begin
            w_frame_nxt = '0;
        end else if (w_last) begin
            w_frame_nxt = r_frame + 1'b1;
        end else begin
            w_frame_nxt = r_frame;
        end
    end

    // State, row and frame registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= 3'd0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    assign ready_o  = w_ready;
    assign accept_o = w_accept;
    assign valid_o  = (r_state == EMIT);
    assign last_o   = w_last;
    assign done_o   = w_done;
    assign row_o    = r_row;

endmodule

// File: rtl/window_serializer_5x5.sv
// Captures a 25-pixel window and replays it as five 5-pixel rows, one per
// clock, using the controller's row select to drive a per-column row mux.
module window_serializer_5x5
    import window_pkg::*;
#(
    parameter int ROWS = 7,
    parameter int COLS = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] d0_i,
    input  logic [PIX_W-1:0] d1_i,
    input  logic [PIX_W-1:0] d2_i,
    input  logic [PIX_W-1:0] d3_i,
    input  logic [PIX_W-1:0] d4_i,
    input  logic [PIX_W-1:0] d5_i,
    input  logic [PIX_W-1:0] d6_i,
    input  logic [PIX_W-1:0] d7_i,
    input  logic [PIX_W-1:0] d8_i,
    input  logic [PIX_W-1:0] d9_i,
    input  logic [PIX_W-1:0] d10_i,
    input  logic [PIX_W-1:0] d11_i,
    input  logic [PIX_W-1:0] d12_i,
    input  logic [PIX_W-1:0] d13_i,
    input  logic [PIX_W-1:0] d14_i,
    input  logic [PIX_W-1:0] d15_i,
    input  logic [PIX_W-1:0] d16_i,
    input  logic [PIX_W-1:0] d17_i,
    input  logic [PIX_W-1:0] d18_i,
    input  logic [PIX_W-1:0] d19_i,
    input  logic [PIX_W-1:0] d20_i,
    input  logic [PIX_W-1:0] d21_i,
    input  logic [PIX_W-1:0] d22_i,
    input  logic [PIX_W-1:0] d23_i,
    input  logic [PIX_W-1:0] d24_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [PIX_W-1:0] p0_o,
    output logic [PIX_W-1:0] p1_o,
    output logic [PIX_W-1:0] p2_o,
    output logic [PIX_W-1:0] p3_o,
    output logic [PIX_W-1:0] p4_o,
    output logic [2:0]       row_o,
    output logic             valid_o,
    output logic             last_o,
    output logic             done_o
);

    logic [PIX_W-1:0] w_din [WIN_PIX];
    logic [PIX_W-1:0] r_win [WIN_PIX];
    logic [PIX_W-1:0] w_pix [WIN_DIM];
    logic             w_accept;
    row_t             w_row;

    assign w_din = '{d0_i,  d1_i,  d2_i,  d3_i,  d4_i,
                     d5_i,  d6_i,  d7_i,  d8_i,  d9_i,
                     d10_i, d11_i, d12_i, d13_i, d14_i,
                     d15_i, d16_i, d17_i, d18_i, d19_i,
                     d20_i, d21_i, d22_i, d23_i, d24_i};

    window_serializer_5x5_controller #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .accept_o (w_accept),
        .valid_o  (valid_o),
        .last_o   (last_o),
        .done_o   (done_o),
        .row_o    (w_row)
    );

    // Window register: cleared on reset, loaded only on an accepted window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN_PIX; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < WIN_PIX; i++) begin
                r_win[i] <= w_din[i];
            end
        end
    end

    // Per-column 5:1 row mux selected by the current row index.
    always_comb begin
        for (int c = 0; c < WIN_DIM; c++) begin
            w_pix[c] = '0;
            case (w_row)
                3'd0:    w_pix[c] = r_win[c];
                3'd1:    w_pix[c] = r_win[5 + c];
                3'd2:    w_pix[c] = r_win[10 + c];
                3'd3:    w_pix[c] = r_win[15 + c];
                3'd4:    w_pix[c] = r_win[20 + c];
                default: w_pix[c] = '0;
            endcase
        end
    end

    assign p0_o  = w_pix[0];
    assign p1_o  = w_pix[1];
    assign p2_o  = w_pix[2];
    assign p3_o  = w_pix[3];
    assign p4_o  = w_pix[4];
    assign row_o = w_row;

endmodule

// File: tb/tb_window_serializer_5x5.sv
// Directed self-checking bench for window_serializer_5x5: a default 7x7
// instance and a 1x1 instance driven from the same stimulus.
module tb_window_serializer_5x5;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_i;
    logic [7:0] d [25];
    logic       ready_o, valid_o, last_o, done_o;
    logic [7:0] p [5];
    logic [2:0] row_o;
    logic       ready1, valid1, last1, done1;
    logic [7:0] p1 [5];
    logic [2:0] row1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    window_serializer_5x5 dut (
        .clk(clk), .rst(rst),
        .d0_i(d[0]),   .d1_i(d[1]),   .d2_i(d[2]),   .d3_i(d[3]),   .d4_i(d[4]),
        .d5_i(d[5]),   .d6_i(d[6]),   .d7_i(d[7]),   .d8_i(d[8]),   .d9_i(d[9]),
        .d10_i(d[10]), .d11_i(d[11]), .d12_i(d[12]), .d13_i(d[13]), .d14_i(d[14]),
        .d15_i(d[15]), .d16_i(d[16]), .d17_i(d[17]), .d18_i(d[18]), .d19_i(d[19]),
        .d20_i(d[20]), .d21_i(d[21]), .d22_i(d[22]), .d23_i(d[23]), .d24_i(d[24]),
        .valid_i(valid_i), .ready_o(ready_o),
        .p0_o(p[0]), .p1_o(p[1]), .p2_o(p[2]), .p3_o(p[3]), .p4_o(p[4]),
        .row_o(row_o), .valid_o(valid_o), .last_o(last_o), .done_o(done_o)
    );

    window_serializer_5x5 #(.ROWS(1), .COLS(1)) dut1 (
        .clk(clk), .rst(rst),
        .d0_i(d[0]),   .d1_i(d[1]),   .d2_i(d[2]),   .d3_i(d[3]),   .d4_i(d[4]),
        .d5_i(d[5]),   .d6_i(d[6]),   .d7_i(d[7]),   .d8_i(d[8]),   .d9_i(d[9]),
        .d10_i(d[10]), .d11_i(d[11]), .d12_i(d[12]), .d13_i(d[13]), .d14_i(d[14]),
        .d15_i(d[15]), .d16_i(d[16]), .d17_i(d[17]), .d18_i(d[18]), .d19_i(d[19]),
        .d20_i(d[20]), .d21_i(d[21]), .d22_i(d[22]), .d23_i(d[23]), .d24_i(d[24]),
        .valid_i(valid_i), .ready_o(ready1),
        .p0_o(p1[0]), .p1_o(p1[1]), .p2_o(p1[2]), .p3_o(p1[3]), .p4_o(p1[4]),
        .row_o(row1), .valid_o(valid1), .last_o(last1), .done_o(done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input logic [7:0] base, input bit incr);
        for (int k = 0; k < 25; k++) d[k] = incr ? 8'(base + k) : base;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid_i = 1'b1;
        set_win(8'hAA, 1'b0);
        step();
        step();
        rst = 1'b0;
        valid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
        n_checks++; if (last_o !== 1'b0) begin n_errors++; $display("FAIL reset_last got %b exp 0", last_o); end
        n_checks++; if (done_o !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", done_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
        n_checks++; if (row_o !== 3'd0) begin n_errors++; $display("FAIL reset_row got %0d exp 0", row_o); end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (p[c] !== 8'h00) begin n_errors++; $display("FAIL reset_pix c=%0d got %h exp 00", c, p[c]); end
        end
    endtask

    task automatic test_single();
        set_win(8'h00, 1'b1);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int r = 0; r < 5; r++) begin
            n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL single_valid r=%0d got %b exp 1", r, valid_o); end
            n_checks++; if (row_o !== 3'(r)) begin n_errors++; $display("FAIL single_row got %0d exp %0d", row_o, r); end
            n_checks++; if (last_o !== (r == 4)) begin n_errors++; $display("FAIL single_last r=%0d got %b", r, last_o); end
            n_checks++; if (ready_o !== (r == 4)) begin n_errors++; $display("FAIL single_ready r=%0d got %b", r, ready_o); end
            for (int c = 0; c < 5; c++) begin
                n_checks++;
                if (p[c] !== 8'(5 * r + c)) begin
                    n_errors++; $display("FAIL single_pix r=%0d c=%0d got %0d exp %0d", r, c, p[c], 5 * r + c);
                end
            end
            step();
        end
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL single_idle_valid got %b exp 0", valid_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_errors++; $display("FAIL single_idle_ready got %b exp 1", ready_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_pix;
        set_win(8'h11, 1'b0);
        valid_i = 1'b1;
        step();
        set_win(8'h22, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp_pix = (i < 5) ? 8'h11 : 8'h22;
            n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL b2b_valid i=%0d got %b exp 1", i, valid_o); end
            n_checks++; if (row_o !== 3'(i % 5)) begin n_errors++; $display("FAIL b2b_row i=%0d got %0d exp %0d", i, row_o, i % 5); end
            n_checks++; if (p[2] !== exp_pix) begin n_errors++; $display("FAIL b2b_pix i=%0d got %h exp %h", i, p[2], exp_pix); end
            if (i == 4) begin
                n_checks++; if (ready_o !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_row4 got %b exp 1", ready_o); end
            end
            if (i == 5) valid_i = 1'b0;
            step();
        end
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL b2b_end_valid got %b exp 0", valid_o); end
    endtask

    task automatic test_ignore();
        set_win(8'h30, 1'b1);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                n_checks++;
                if (p[c] !== 8'(8'h30 + 5 * r + c)) begin
                    n_errors++; $display("FAIL ignore_first r=%0d c=%0d got %h exp %h", r, c, p[c], 8'(8'h30 + 5 * r + c));
                end
            end
            if (r >= 1 && r <= 3) begin
                set_win(8'hFF, 1'b0);
                valid_i = 1'b1;
            end
            if (r == 4) begin
                set_win(8'h40, 1'b1);
                valid_i = 1'b1;
            end
            step();
        end
        valid_i = 1'b0;
        for (int r = 0; r < 5; r++) begin
            n_checks++; if (row_o !== 3'(r)) begin n_errors++; $display("FAIL ignore_row got %0d exp %0d", row_o, r); end
            for (int c = 0; c < 5; c++) begin
                n_checks++;
                if (p[c] !== 8'(8'h40 + 5 * r + c)) begin
                    n_errors++; $display("FAIL ignore_second r=%0d c=%0d got %h exp %h", r, c, p[c], 8'(8'h40 + 5 * r + c));
                end
            end
            step();
        end
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL ignore_end_valid got %b exp 0", valid_o); end
    endtask

    task automatic test_reset_mid();
        set_win(8'h50, 1'b1);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        step();
        n_checks++; if (row_o !== 3'd2) begin n_errors++; $display("FAIL rmid_pre_row got %0d exp 2", row_o); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL rmid_valid got %b exp 0", valid_o); end
        n_checks++; if (ready_o !== 1'b1) begin n_errors++; $display("FAIL rmid_ready got %b exp 1", ready_o); end
        n_checks++; if (row_o !== 3'd0) begin n_errors++; $display("FAIL rmid_row got %0d exp 0", row_o); end
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (p[c] !== 8'h00) begin n_errors++; $display("FAIL rmid_pix c=%0d got %h exp 00", c, p[c]); end
        end
        step();
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL rmid_no_resume got %b exp 0", valid_o); end
        set_win(8'h60, 1'b1);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int r = 0; r < 5; r++) begin
            n_checks++; if (row_o !== 3'(r)) begin n_errors++; $display("FAIL rmid_new_row got %0d exp %0d", row_o, r); end
            n_checks++;
            if (p[0] !== 8'(8'h60 + 5 * r)) begin
                n_errors++; $display("FAIL rmid_new_pix r=%0d got %h exp %h", r, p[0], 8'(8'h60 + 5 * r));
            end
            step();
        end
    endtask

    task automatic test_frame();
        int n_done;
        n_done = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_win(8'h00, 1'b1);
        valid_i = 1'b1;
        step();
        for (int w = 0; w < 50; w++) begin
            for (int r = 0; r < 5; r++) begin
                n_checks++; if (valid_o !== 1'b1) begin n_errors++; $display("FAIL frame_valid w=%0d r=%0d got %b exp 1", w, r, valid_o); end
                n_checks++; if (row_o !== 3'(r)) begin n_errors++; $display("FAIL frame_row w=%0d got %0d exp %0d", w, row_o, r); end
                n_checks++; if (last_o !== (r == 4)) begin n_errors++; $display("FAIL frame_last w=%0d r=%0d got %b", w, r, last_o); end
                n_checks++;
                if (done_o !== (r == 4 && w == 48)) begin
                    n_errors++; $display("FAIL frame_done w=%0d r=%0d got %b exp %b", w, r, done_o, (r == 4 && w == 48));
                end
                n_checks++; if (p[0] !== 8'(5 * r)) begin n_errors++; $display("FAIL frame_pix w=%0d r=%0d got %0d exp %0d", w, r, p[0], 5 * r); end
                n_checks++; if (done1 !== (r == 4)) begin n_errors++; $display("FAIL one_done w=%0d r=%0d got %b exp %b", w, r, done1, (r == 4)); end
                if (done_o === 1'b1) n_done++;
                if (w == 49 && r == 4) valid_i = 1'b0;
                step();
            end
        end
        n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL frame_done_count got %0d exp 1", n_done); end
        n_checks++; if (valid_o !== 1'b0) begin n_errors++; $display("FAIL frame_end_valid got %b exp 0", valid_o); end
    endtask

    task automatic test_single_frame();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int w = 0; w < 2; w++) begin
            set_win(8'h70, 1'b1);
            valid_i = 1'b1;
            step();
            valid_i = 1'b0;
            for (int r = 0; r < 5; r++) begin
                n_checks++; if (last1 !== (r == 4)) begin n_errors++; $display("FAIL one_last w=%0d r=%0d got %b", w, r, last1); end
                n_checks++; if (done1 !== (r == 4)) begin n_errors++; $display("FAIL one_done_gap w=%0d r=%0d got %b exp %b", w, r, done1, (r == 4)); end
                n_checks++; if (done_o !== 1'b0) begin n_errors++; $display("FAIL dflt_done w=%0d r=%0d got %b exp 0", w, r, done_o); end
                step();
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0;
        set_win(8'h00, 1'b0);
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore();
        test_reset_mid();
        test_frame();
        test_single_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
